cplx_matmul_param: RTL



---
 rtl/cmm_pkg.sv | 32 +++
 rtl/cplx_matmul_param_mac.sv | 61 ++++++
 rtl/cplx_matmul_param.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/cmm_pkg.sv
// Shared types and helpers for the complex matrix multiplier.
// The state encoding is fixed because it is exported on a debug port.
package cmm_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } cmm_state_e;

  // Widest accumulator handled by sat_trunc; covers DW up to 62 with N up to 16.
  localparam int MAX_W = 128;

  function automatic int slice_idx(input int r, input int c, input int n);
    return r * n + c;
  endfunction

  // Clamp a sign-extended accumulator of width accw into the signed dw-bit range.
  function automatic logic signed [MAX_W-1:0] sat_trunc(input logic signed [MAX_W-1:0] acc,
                                                        input int accw, input int dw);
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    hi = (MAX_W'(1) <<< (dw - 1)) - MAX_W'(1);
    lo = -hi - MAX_W'(1);
    if (accw <= dw) return acc;
    if (acc > hi) return hi;
    if (acc < lo) return lo;
    return acc;
  endfunction

endpackage

// File: rtl/cplx_matmul_param_mac.sv
// Single complex MAC: registered product (optionally conjugating A), then
// arithmetic shift by FRAC and accumulate one cycle later.
module cplx_mac #(
  parameter int DW   = 32,
  parameter int FRAC = 29,
  parameter int ACCW = 68
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   prod_en,
  input  logic                   conj,
  input  logic signed [DW-1:0]   a_re,
  input  logic signed [DW-1:0]   a_im,
  input  logic signed [DW-1:0]   b_re,
  input  logic signed [DW-1:0]   b_im,
  output logic signed [ACCW-1:0] acc_re,
  output logic signed [ACCW-1:0] acc_im
);

  localparam int PW = 2 * DW + 1;

  logic signed [PW-1:0] rr, ii, ri, ir;
  logic signed [PW-1:0] pr_d, pi_d;
  logic signed [PW-1:0] pr_q, pi_q;
  logic                 pvalid;

  // Conjugation folds the imag negation into the sums, so -2^(DW-1) never has to be negated.
  always_comb begin
    rr   = PW'(a_re) * PW'(b_re);
    ii   = PW'(a_im) * PW'(b_im);
    ri   = PW'(a_re) * PW'(b_im);
    ir   = PW'(a_im) * PW'(b_re);
    pr_d = conj ? (rr + ii) : (rr - ii);
    pi_d = conj ? (ri - ir) : (ri + ir);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pr_q   <= '0;
      pi_q   <= '0;
      pvalid <= 1'b0;
      acc_re <= '0;
      acc_im <= '0;
    end else begin
      pvalid <= prod_en;
      if (prod_en) begin
        pr_q <= pr_d;
        pi_q <= pi_d;
      end
      if (clr) begin
        acc_re <= '0;
        acc_im <= '0;
      end else if (pvalid) begin
        acc_re <= acc_re + ACCW'(pr_q >>> FRAC);
        acc_im <= acc_im + ACCW'(pi_q >>> FRAC);
      end
    end
  end

endmodule

// File: rtl/cplx_matmul_param.sv
// Complex NxN fixed-point matrix multiplier C = op(A) x B, op(A) = A or A^H per transaction.
// Build option CMM_SAT_EN: saturate each result part on write instead of wrapping.
module cplx_matmul_param
  import cmm_pkg::*;
#(
  parameter int N    = 8,
  parameter int DW   = 32,
  parameter int FRAC = 29
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              conj_a,
  input  logic [N*N*DW-1:0] a_real,
  input  logic [N*N*DW-1:0] a_imag,
  input  logic [N*N*DW-1:0] b_real,
  input  logic [N*N*DW-1:0] b_imag,
  output logic [N*N*DW-1:0] out_real,
  output logic [N*N*DW-1:0] out_imag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam int ACCW = 2 * DW + $clog2(N);
  localparam int KW   = $clog2(N);
  localparam int AW   = $clog2(N * N);
  localparam logic [KW-1:0] LAST = KW'(N - 1);

  // Handshake: operands transfer on a cycle with in_valid && in_ready (in_ready is
  // high only in IDLE); a result transfers on out_valid && out_ready, and out_valid
  // and out_* stay stable until then.

  cmm_state_e             state;
  logic [KW-1:0]          i, j, k;
  logic                   drain, conj_q;
  logic                   accept, prod_en, clr;
  logic [AW-1:0]          a_idx, b_idx, c_idx;
  logic signed [DW-1:0]   a_re_q [N*N];
  logic signed [DW-1:0]   a_im_q [N*N];
  logic signed [DW-1:0]   b_re_q [N*N];
  logic signed [DW-1:0]   b_im_q [N*N];
  logic [DW-1:0]          out_re_q [N*N];
  logic [DW-1:0]          out_im_q [N*N];
  logic signed [ACCW-1:0] acc_re, acc_im;
  logic [DW-1:0]          wr_re, wr_im;

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;
  assign accept    = in_ready && in_valid;
  assign prod_en   = (state == S_MAC) && !drain;
  assign clr       = accept || (state == S_WRITE);

  // A^H reads A[k][i]; the imag negation happens inside the MAC.
  always_comb begin
    if (conj_q) a_idx = AW'(slice_idx(int'(k), int'(i), N));
    else        a_idx = AW'(slice_idx(int'(i), int'(k), N));
    b_idx = AW'(slice_idx(int'(k), int'(j), N));
    c_idx = AW'(slice_idx(int'(i), int'(j), N));
  end

  for (genvar g = 0; g < N * N; g++) begin : g_el
    always_ff @(posedge clk) begin
      if (accept) begin
        a_re_q[g] <= a_real[g*DW +: DW];
        a_im_q[g] <= a_imag[g*DW +: DW];
        b_re_q[g] <= b_real[g*DW +: DW];
        b_im_q[g] <= b_imag[g*DW +: DW];
      end
    end
    assign out_real[g*DW +: DW] = out_re_q[g];
    assign out_imag[g*DW +: DW] = out_im_q[g];
  end

  cplx_mac #(
    .DW  (DW),
    .FRAC(FRAC),
    .ACCW(ACCW)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .prod_en(prod_en),
    .conj   (conj_q),
    .a_re   (a_re_q[a_idx]),
    .a_im   (a_im_q[a_idx]),
    .b_re   (b_re_q[b_idx]),
    .b_im   (b_im_q[b_idx]),
    .acc_re (acc_re),
    .acc_im (acc_im)
  );

  always_comb begin
`ifdef CMM_SAT_EN
    wr_re = DW'(sat_trunc(MAX_W'(acc_re), ACCW, DW));
    wr_im = DW'(sat_trunc(MAX_W'(acc_im), ACCW, DW));
`else
    wr_re = DW'(acc_re);
    wr_im = DW'(acc_im);
`endif
  end

  // Per element: N issue cycles, one drain cycle for the last product, one write cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      drain     <= 1'b0;
      conj_q    <= 1'b0;
      out_valid <= 1'b0;
      out_re_q  <= '{default: '0};
      out_im_q  <= '{default: '0};
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            conj_q <= conj_a;
            i      <= '0;
            j      <= '0;
            k      <= '0;
            drain  <= 1'b0;
            state  <= S_MAC;
          end
        end
        S_MAC: begin
          if (drain) begin
            drain <= 1'b0;
            state <= S_WRITE;
          end else if (k == LAST) begin
            drain <= 1'b1;
          end else begin
            k <= k + 1'b1;
          end
        end
        S_WRITE: begin
          out_re_q[c_idx] <= wr_re;
          out_im_q[c_idx] <= wr_im;
          k               <= '0;
          state           <= S_MAC;
          if (j == LAST) begin
            j <= '0;
            if (i == LAST) begin
              state     <= S_DONE;
              out_valid <= 1'b1;
            end else begin
              i <= i + 1'b1;
            end
          end else begin
            j <= j + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
